cp0_reg: RTL and testbench



---
 rtl/mips32_cp0_pkg.sv | 31 +++
 rtl/cp0_timer.sv | 56 +++++
 rtl/cp0_reg.sv | 132 +++++++++++++
 tb/tb_cp0_reg.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_cp0_pkg.sv
// Shared CP0 constants: register numbers, exception codes, Status/Cause bit
// positions and reset values used by the CP0 register block and its timer.
package mips32_cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int CAUSE_TI   = 30;
  localparam int CAUSE_BD   = 31;

  // Only IM[15:8], EXL and IE respond to MTC0 Status.
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] STATUS_RST   = 32'h0040_0000;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running Count (optionally half rate), Compare,
// and the sticky timer interrupt flag TI.
module cp0_timer
  import mips32_cp0_pkg::*;
#(
  parameter bit COUNT_HALF_RATE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        phase_q, phase_d;
  logic        ti_q, ti_d;
  logic        inc;

  always_comb begin
    phase_d   = COUNT_HALF_RATE ? ~phase_q : 1'b0;
    inc       = COUNT_HALF_RATE ? phase_q : 1'b1;
    count_d   = count_we ? wdata : count_q + {31'd0, inc};
    compare_d = compare_we ? wdata : compare_q;
    // Compare write acknowledges the interrupt even if the match fires now.
    if (compare_we)
      ti_d = 1'b0;
    else if (count_q == compare_q)
      ti_d = 1'b1;
    else
      ti_d = ti_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      compare_q <= '0;
      phase_q   <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      phase_q   <= phase_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_reg.sv
// CP0 register block: MTC0/MFC0 access, precise exception and ERET state
// updates, interrupt pending/request generation, and the Count/Compare timer.
module cp0_reg
  import mips32_cp0_pkg::*;
#(
  parameter logic [31:0] PRID            = 32'h0001_8000,
  parameter logic [31:0] CONFIG_VAL      = 32'h0000_8000,
  parameter bit          COUNT_HALF_RATE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic [5:0]  int_i,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        int_req,
  output logic        timer_int
);

  logic [31:0] status_q, status_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        bd_q, bd_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [4:0]  exccode_q, exccode_d;

  logic [31:0] count, compare;
  logic        ti;

  cp0_timer #(
    .COUNT_HALF_RATE(COUNT_HALF_RATE)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .count_we  (we && (waddr == REG_COUNT)),
    .compare_we(we && (waddr == REG_COMPARE)),
    .wdata     (wdata),
    .count_o   (count),
    .compare_o (compare),
    .ti_o      (ti)
  );

  always_comb begin
    status_d   = status_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;
    ip_hw_d    = int_i;

    // The WB-stage write is the older instruction, so it lands first and the
    // exception fields below override it.
    if (we) begin
      case (waddr)
        REG_STATUS: status_d = (status_q & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
        REG_CAUSE:  ip_sw_d  = wdata[9:8];
        REG_EPC:    epc_d    = wdata;
        default:    ;
      endcase
    end

    if (exc_valid) begin
      exccode_d = exc_code;
      if (!status_d[STATUS_EXL]) begin
        epc_d = exc_bd ? exc_pc - 32'd4 : exc_pc;
        bd_d  = exc_bd;
      end
      status_d[STATUS_EXL] = 1'b1;
      if (exc_code == EXC_ADEL || exc_code == EXC_ADES)
        badvaddr_d = exc_badvaddr;
    end else if (eret) begin
      status_d[STATUS_EXL] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q   <= STATUS_RST;
      epc_q      <= '0;
      badvaddr_q <= '0;
      bd_q       <= 1'b0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      exccode_q  <= EXC_INT;
    end else begin
      status_q   <= status_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      bd_q       <= bd_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ip_hw_d;
      exccode_q  <= exccode_d;
    end
  end

  // IP7 is shared between hardware line 5 and the timer.
  assign cause_o = {bd_q, ti, 14'd0, ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q,
                    1'b0, exccode_q, 2'b00};
  assign status_o  = status_q;
  assign epc_o     = epc_q;
  assign timer_int = ti;
  assign int_req   = status_q[STATUS_IE] & ~status_q[STATUS_EXL]
                   & |(cause_o[15:8] & status_q[15:8]);

  always_comb begin
    case (raddr)
      REG_BADVADDR: rdata = badvaddr_q;
      REG_COUNT:    rdata = count;
      REG_COMPARE:  rdata = compare;
      REG_STATUS:   rdata = status_q;
      REG_CAUSE:    rdata = cause_o;
      REG_EPC:      rdata = epc_q;
      REG_PRID:     rdata = PRID;
      REG_CONFIG:   rdata = CONFIG_VAL;
      default:      rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_reg.sv
// Directed bench for cp0_reg: a field-level CP0 model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_cp0_reg;

  localparam bit          HALF  = 1'b1;
  localparam logic [31:0] PRID  = 32'h0001_8000;
  localparam logic [31:0] CFG   = 32'h0000_8000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr = '0;
  logic [31:0] rdata;
  logic [5:0]  int_i = '0;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_code = '0;
  logic [31:0] exc_pc = '0;
  logic        exc_bd = 1'b0;
  logic [31:0] exc_badvaddr = '0;
  logic        eret = 1'b0;
  logic [31:0] status_o, cause_o, epc_o;
  logic        int_req, timer_int;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  cp0_reg #(
    .PRID(PRID), .CONFIG_VAL(CFG), .COUNT_HALF_RATE(HALF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .int_i(int_i), .exc_valid(exc_valid),
    .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badvaddr(exc_badvaddr), .eret(eret), .status_o(status_o),
    .cause_o(cause_o), .epc_o(epc_o), .int_req(int_req), .timer_int(timer_int)
  );

  typedef struct packed {
    logic [31:0] count, compare, status, epc, badv;
    logic        phase, ti, bd;
    logic [5:0]  ip_hw;
    logic [1:0]  ip_sw;
    logic [4:0]  code;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r = '0;
    r.status = 32'h0040_0000;
    return r;
  endfunction

  function automatic model_t model_next(model_t s);
    model_t n = s;
    n.phase = HALF ? ~s.phase : 1'b0;
    if (!HALF || s.phase) n.count = s.count + 32'd1;
    if (s.count == s.compare) n.ti = 1'b1;
    n.ip_hw = int_i;
    if (we) begin
      if (waddr == 5'd9)  n.count = wdata;
      if (waddr == 5'd11) begin n.compare = wdata; n.ti = 1'b0; end
      if (waddr == 5'd12) n.status = {s.status[31:16], wdata[15:8], s.status[7:2], wdata[1:0]};
      if (waddr == 5'd13) n.ip_sw = wdata[9:8];
      if (waddr == 5'd14) n.epc = wdata;
    end
    if (exc_valid) begin
      n.code = exc_code;
      if (n.status[1] == 1'b0) begin
        n.epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
        n.bd  = exc_bd;
      end
      n.status[1] = 1'b1;
      if (exc_code == 5'd4 || exc_code == 5'd5) n.badv = exc_badvaddr;
    end else if (eret) begin
      n.status[1] = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [31:0] m_cause(model_t s);
    logic [31:0] c = '0;
    c[31]    = s.bd;
    c[30]    = s.ti;
    c[15]    = s.ip_hw[5] | s.ti;
    c[14:10] = s.ip_hw[4:0];
    c[9:8]   = s.ip_sw;
    c[6:2]   = s.code;
    return c;
  endfunction

  function automatic logic [31:0] m_read(model_t s, logic [4:0] a);
    case (a)
      5'd8:    return s.badv;
      5'd9:    return s.count;
      5'd11:   return s.compare;
      5'd12:   return s.status;
      5'd13:   return m_cause(s);
      5'd14:   return s.epc;
      5'd15:   return PRID;
      5'd16:   return CFG;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_intreq(model_t s);
    logic [31:0] c = m_cause(s);
    return s.status[0] & ~s.status[1] & |(c[15:8] & s.status[15:8]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_next(m);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("status_o", status_o, m.status);
      check("cause_o", cause_o, m_cause(m));
      check("epc_o", epc_o, m.epc);
      check("rdata", rdata, m_read(m, raddr));
      check("int_req", {31'd0, int_req}, {31'd0, m_intreq(m)});
      check("timer_int", {31'd0, timer_int}, {31'd0, m.ti});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    cyc();
    we = 1'b0;
  endtask

  task automatic take_exc(input logic [4:0] c, input logic [31:0] pc,
                          input logic bd, input logic [31:0] bva);
    exc_valid = 1'b1; exc_code = c; exc_pc = pc; exc_bd = bd; exc_badvaddr = bva;
    cyc();
    exc_valid = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input string name, input logic [31:0] exp);
    raddr = a;
    #1;
    check(name, rdata, exp);
  endtask

  initial begin
    bit seen;
    repeat (2) cyc();
    chk_en = 1'b1;
    rd(5'd12, "rst_status", 32'h0040_0000);
    rd(5'd13, "rst_cause", 32'h0000_0000);
    rd(5'd15, "rst_prid", 32'h0001_8000);
    rd(5'd16, "rst_config", 32'h0000_8000);
    rd(5'd14, "rst_epc", 32'h0000_0000);

    rst_n = 1'b1;
    mtc0(5'd11, 32'd10);
    raddr = 5'd9;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (timer_int) begin seen = 1'b1; break; end
      cyc();
    end
    check("ti_seen", {31'd0, seen}, 32'd1);
    check("ti_count", rdata, 32'd10);
    mtc0(5'd12, 32'h0000_8001);
    check("ti_status", status_o, 32'h0040_8001);
    check("ti_intreq", {31'd0, int_req}, 32'd1);
    mtc0(5'd11, 32'd100);
    check("ti_clear", {31'd0, timer_int}, 32'd0);

    take_exc(5'd4, 32'h100, 1'b1, 32'h203);
    check("exc_epc", epc_o, 32'hFC);
    check("exc_bd", {31'd0, cause_o[31]}, 32'd1);
    check("exc_code", {27'd0, cause_o[6:2]}, 32'd4);
    check("exc_exl", {31'd0, status_o[1]}, 32'd1);
    rd(5'd8, "exc_badv", 32'h203);
    take_exc(5'd8, 32'h500, 1'b0, 32'h0);
    check("nest_epc", epc_o, 32'hFC);
    check("nest_code", {27'd0, cause_o[6:2]}, 32'd8);
    rd(5'd8, "nest_badv", 32'h203);
    eret = 1'b1; cyc(); eret = 1'b0;
    check("eret_exl", {31'd0, status_o[1]}, 32'd0);
    check("eret_epc", epc_o, 32'hFC);

    we = 1'b1; waddr = 5'd12; wdata = 32'h0000_FF01;
    take_exc(5'd10, 32'h600, 1'b0, 32'h0);
    we = 1'b0;
    check("same_status", status_o, 32'h0040_FF03);
    check("same_epc", epc_o, 32'h600);
    eret = 1'b1;
    take_exc(5'd12, 32'h700, 1'b0, 32'h0);
    eret = 1'b0;
    check("eret_ignored", {31'd0, status_o[1]}, 32'd1);
    check("held_epc", epc_o, 32'h600);
    eret = 1'b1; cyc(); eret = 1'b0;

    mtc0(5'd9, 32'd5);
    rd(5'd9, "count_wr", 32'd5);
    mtc0(5'd9, 32'hFFFF_FFFF);
    cyc(); cyc();
    rd(5'd9, "count_wrap", 32'd0);
    mtc0(5'd13, 32'hFFFF_FFFF);
    check("cause_ipsw", {30'd0, cause_o[9:8]}, 32'd3);
    mtc0(5'd15, 32'd0);
    rd(5'd15, "prid_ro", 32'h0001_8000);
    rd(5'd20, "unmapped", 32'd0);

    mtc0(5'd12, 32'h0000_0401);
    int_i = 6'b000001;
    #1;
    check("ip2_lag", {31'd0, int_req}, 32'd0);
    cyc();
    check("ip2_set", {31'd0, cause_o[10]}, 32'd1);
    check("ip2_intreq", {31'd0, int_req}, 32'd1);
    int_i = 6'b000000;

    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_status", status_o, 32'h0040_0000);
    rd(5'd9, "mid_rst_count", 32'd0);
    check("mid_rst_epc", epc_o, 32'd0);
    cyc();
    rst_n = 1'b1;
    repeat (4) cyc();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
